shift_round_saturate: RTL and testbench
=======================================

// Module: shift_round_saturate
// PURPOSE
//  Downstream stage of the product/invert multiplier in the pt_feedback chain: takes the
//  signed full-range product, applies a programmable arithmetic right shift with
//  round-half-up, and saturates the result to DAC width.
//  - Pipelined with valid qualification.
//  - Provides per-sample, sticky and counted saturation status for the register map.
// PARAMETERS
//  IN_WIDTH    35  signed input width (2*18-1, the multiplier product width)
//  OUT_WIDTH   14  signed output width (DAC)
//  SHIFT_WIDTH 6   width of shift control
//  CNT_WIDTH   16  saturation event counter width
// PORTS
//  clk_i        in   1            system clock
//  rst_ni       in   1            synchronous active-low reset
//  data_i       in   IN_WIDTH     signed product sample
//  valid_i      in   1            data_i qualifier
//  shift_i      in   SHIFT_WIDTH  right-shift amount (unsigned)
//  enable_i     in   1            1 = pass signal, 0 = force zero output
//  clr_sat_i    in   1            clears sat_sticky_o and sat_count_o
//  data_o       out  OUT_WIDTH    signed scaled/saturated sample
//  valid_o      out  1            data_o qualifier
//  sat_o        out  1            current data_o was clipped
//  sat_sticky_o out  1            a clip occurred since last clear/reset
//  sat_count_o  out  CNT_WIDTH    number of clipped samples, saturating at all-ones
// BEHAVIOUR
//  - Clocking: single clock clk_i; one clock; reset is synchronous and active-low; rst_ni is
//    sampled on the rising edge of clk_i.
//  - Reset: all pipeline registers and all outputs = 0. A reset mid-operation drops all
//    in-flight samples, and no valid_o follows.
//  - Latency: fixed 3 cycles from valid_i to valid_o; one sample per cycle. There is no
//    backpressure.
//  - S1 (valid_i=1): register data_i, valid, and shift_eff.
//    - shift_eff = min(shift_i, IN_WIDTH-1).
//    - shift_i is sampled with its own data, so a change of shift_i never mixes samples.
//  - S2: rounding and shift, computed in IN_WIDTH+1 bits so the rounding add cannot overflow.
//    - If shift_eff > 0: r = (x + 2^(shift_eff-1)) >>> shift_eff (arithmetic shift).
//    - If shift_eff = 0: r = x.
//    - The result is round-half-up: +2.5 -> 3, -2.5 -> -2.
//  - S3: saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//    - sat = r outside that range.
//    - enable_i is sampled at S3: if 0, data_o = 0 and sat_o = 0, and no counting occurs.
//  - Hold: data_o and sat_o update only on cycles where valid_o=1, and hold between valid
//    outputs. valid_o is a 1-cycle pulse per sample.
//  - Status:
//    - On each valid output with sat=1 and enable_i=1: sat_sticky_o <= 1 and
//      sat_count_o <= sat_count_o + 1, stopping at 2^CNT_WIDTH-1 (no wrap).
//    - clr_sat_i=1 zeroes sticky and count on the next edge.
//    - A clip event in the same cycle as clr_sat_i is discarded: clear has priority.
//  - Output: data_o is registered (no combinational path from inputs to outputs).
// STRUCTURE
//  - pt_feedback_pkg: default widths (PRODUCT_WIDTH=35, DAC_WIDTH=14, SHIFT_WIDTH=6,
//    SAT_CNT_WIDTH=16) shared with the multiplier and DAC interface.
//  - Sub-module round_shift (S1-S2: clamp, round, arithmetic shift); the top holds saturation
//    and status logic.
// TESTING
//  1. shift=21, data=3*2^21 (6291456), valid 1 cycle -> 3 cycles later: valid_o pulse,
//     data_o=3, sat_o=0.
//  2. shift=21, data=5*2^20 -> data_o=3; then data=-5*2^20 -> data_o=-2 (round-half-up).
//  3. shift=0, data=10000 then -10000 -> data_o=8191 then -8192; sat_o=1 both;
//     sat_count_o=2; sat_sticky_o=1.
//  4. shift=63 (clamped to 34), data=-2^34 -> data_o=-1; data=2^34-1 -> data_o=1.
//  5. Status: clr_sat_i asserted in the same cycle as a clipped valid_o -> count=0, sticky=0.
//     Then 70000 clips with CNT_WIDTH=16 -> count holds at 65535. enable_i=0 with clipping
//     data -> data_o=0, sat_o=0, count unchanged.
//  6. Continuous valid stream with shift_i changed every cycle -> each output uses the shift
//     sampled with its own input. rst_ni=0 for 1 cycle mid-stream -> all outputs 0, and no
//     valid_o for the flushed samples.

Source files
------------

// File: rtl/shift_round_saturate_pkg.sv
// Default widths shared across the pt_feedback chain (multiplier product, DAC, shift control,
// saturation counter).
package shift_round_saturate_pkg;

  localparam int PRODUCT_WIDTH = 35;
  localparam int DAC_WIDTH     = 14;
  localparam int SHIFT_WIDTH   = 6;
  localparam int SAT_CNT_WIDTH = 16;

endpackage

// File: rtl/shift_round_saturate_if.sv
// Sample/control/status bundle between the product source, the scaler and the register map.
interface shift_round_saturate_if
  import shift_round_saturate_pkg::*;
#(
  parameter int IN_WIDTH    = PRODUCT_WIDTH,
  parameter int OUT_WIDTH   = DAC_WIDTH,
  parameter int SHIFT_WIDTH = shift_round_saturate_pkg::SHIFT_WIDTH,
  parameter int CNT_WIDTH   = SAT_CNT_WIDTH
);

  logic signed [IN_WIDTH-1:0]  data_i;
  logic                        valid_i;
  logic [SHIFT_WIDTH-1:0]      shift_i;
  logic                        enable_i;
  logic                        clr_sat_i;
  logic signed [OUT_WIDTH-1:0] data_o;
  logic                        valid_o;
  logic                        sat_o;
  logic                        sat_sticky_o;
  logic [CNT_WIDTH-1:0]        sat_count_o;

  modport master (
    output data_i, valid_i, shift_i, enable_i, clr_sat_i,
    input  data_o, valid_o, sat_o, sat_sticky_o, sat_count_o
  );

  modport slave (
    input  data_i, valid_i, shift_i, enable_i, clr_sat_i,
    output data_o, valid_o, sat_o, sat_sticky_o, sat_count_o
  );

endinterface

// File: rtl/shift_round_saturate_round_shift.sv
// S1-S2 of the scaler: capture sample with its clamped shift, then round-half-up and
// arithmetic right shift in one extra bit of headroom.
module shift_round_saturate_round_shift
  import shift_round_saturate_pkg::*;
#(
  parameter int IN_WIDTH    = PRODUCT_WIDTH,
  parameter int SHIFT_WIDTH = shift_round_saturate_pkg::SHIFT_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic signed [IN_WIDTH-1:0] data_i,
  input  logic                       valid_i,
  input  logic [SHIFT_WIDTH-1:0]     shift_i,
  output logic signed [IN_WIDTH:0]   data_o,
  output logic                       valid_o
);

  localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT = SHIFT_WIDTH'(IN_WIDTH - 1);

  logic [SHIFT_WIDTH-1:0]      shift_eff;
  logic signed [IN_WIDTH-1:0]  x_q;
  logic [SHIFT_WIDTH-1:0]      shift_q;
  logic                        v1_q;
  logic signed [IN_WIDTH:0]    x_ext;
  logic [IN_WIDTH:0]           half;
  logic signed [IN_WIDTH:0]    sum;
  logic signed [IN_WIDTH:0]    rounded;
  logic signed [IN_WIDTH:0]    r_q;
  logic                        v2_q;

  assign shift_eff = (shift_i > MAX_SHIFT) ? MAX_SHIFT : shift_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q     <= '0;
      shift_q <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        x_q     <= data_i;
        shift_q <= shift_eff;
      end
    end
  end

  // half is 2^(shift-1), or zero when shift is zero, so both cases share one datapath
  assign x_ext   = {x_q[IN_WIDTH-1], x_q};
  assign half    = ({{IN_WIDTH{1'b0}}, 1'b1} << shift_q) >> 1;
  assign sum     = x_ext + $signed(half);
  assign rounded = sum >>> shift_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q  <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        r_q <= rounded;
      end
    end
  end

  assign data_o  = r_q;
  assign valid_o = v2_q;

endmodule

// File: rtl/shift_round_saturate.sv
// Scales the signed multiplier product to DAC width: programmable round/shift, then
// saturation with per-sample, sticky and counted clip status.
module shift_round_saturate
  import shift_round_saturate_pkg::*;
#(
  parameter int IN_WIDTH    = PRODUCT_WIDTH,
  parameter int OUT_WIDTH   = DAC_WIDTH,
  parameter int SHIFT_WIDTH = shift_round_saturate_pkg::SHIFT_WIDTH,
  parameter int CNT_WIDTH   = SAT_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  shift_round_saturate_if.slave  bus
);

  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic signed [IN_WIDTH:0]    r;
  logic                        r_valid;
  logic                        over;
  logic                        under;
  logic                        clip;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic signed [OUT_WIDTH-1:0] data_q;
  logic                        valid_q;
  logic                        sat_q;
  logic                        sticky_q;
  logic [CNT_WIDTH-1:0]        count_q;

  shift_round_saturate_round_shift #(
    .IN_WIDTH    (IN_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_round_shift (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (bus.data_i),
    .valid_i (bus.valid_i),
    .shift_i (bus.shift_i),
    .data_o  (r),
    .valid_o (r_valid)
  );

  assign over    = r > SAT_MAX;
  assign under   = r < SAT_MIN;
  assign clip    = over || under;
  assign sat_val = over  ? SAT_MAX[OUT_WIDTH-1:0] :
                   under ? SAT_MIN[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];

  // data/sat hold between samples; enable only gates what leaves the block
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= r_valid;
      if (r_valid) begin
        data_q <= bus.enable_i ? sat_val : '0;
        sat_q  <= bus.enable_i && clip;
      end
    end
  end

  // clear wins over a clip landing on the same edge; the counter parks at all-ones
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (bus.clr_sat_i) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (r_valid && bus.enable_i && clip) begin
      sticky_q <= 1'b1;
      if (count_q != '1) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign bus.sat_o        = sat_q;
  assign bus.sat_sticky_o = sticky_q;
  assign bus.sat_count_o  = count_q;

endmodule

// File: tb/tb_shift_round_saturate.sv
// Directed bench for shift_round_saturate: transaction model checked every cycle plus
// hand-computed expectations for the documented scenarios.
module tb_shift_round_saturate;

  localparam int IN_WIDTH    = 35;
  localparam int OUT_WIDTH   = 14;
  localparam int SHIFT_WIDTH = 6;
  localparam int CNT_WIDTH   = 16;
  localparam longint OUT_MAX = (64'sd1 <<< (OUT_WIDTH - 1)) - 1;
  localparam longint OUT_MIN = -(64'sd1 <<< (OUT_WIDTH - 1));
  localparam longint CNT_MAX = (64'sd1 <<< CNT_WIDTH) - 1;

  typedef struct {
    longint x;
    int     sh;
    longint due;
  } sample_t;

  logic clk;
  logic rst_ni;

  shift_round_saturate_if #(
    .IN_WIDTH    (IN_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) bus ();

  shift_round_saturate #(
    .IN_WIDTH    (IN_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round-half-up as floor((x + d/2) / d) with d = 2^min(shift, IN_WIDTH-1)
  function automatic longint model_round(input longint x, input int sh);
    int s;
    longint d, n, q;
    s = (sh > IN_WIDTH - 1) ? IN_WIDTH - 1 : sh;
    if (s == 0) return x;
    d = 64'sd1 <<< s;
    n = x + d / 2;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  sample_t pending[$];
  longint  edge_idx = 0;
  logic    m_valid = 1'b0;
  longint  m_data = 0;
  logic    m_sat = 1'b0;
  logic    m_sticky = 1'b0;
  longint  m_count = 0;

  always @(posedge clk) begin
    sample_t s;
    longint  r;
    logic    clip;
    edge_idx++;
    if (!rst_ni) begin
      pending.delete();
      m_valid  = 1'b0;
      m_data   = 0;
      m_sat    = 1'b0;
      m_sticky = 1'b0;
      m_count  = 0;
    end else begin
      m_valid = 1'b0;
      clip    = 1'b0;
      if (pending.size() > 0 && pending[0].due == edge_idx) begin
        s       = pending.pop_front();
        r       = model_round(s.x, s.sh);
        clip    = (r > OUT_MAX) || (r < OUT_MIN);
        m_valid = 1'b1;
        if (bus.enable_i) begin
          m_data = (r > OUT_MAX) ? OUT_MAX : (r < OUT_MIN) ? OUT_MIN : r;
          m_sat  = clip;
        end else begin
          m_data = 0;
          m_sat  = 1'b0;
        end
      end
      if (bus.clr_sat_i) begin
        m_sticky = 1'b0;
        m_count  = 0;
      end else if (m_valid && bus.enable_i && clip) begin
        m_sticky = 1'b1;
        if (m_count < CNT_MAX) m_count++;
      end
      if (bus.valid_i) begin
        s.x   = longint'($signed(bus.data_i));
        s.sh  = int'(bus.shift_i);
        s.due = edge_idx + 2;
        pending.push_back(s);
      end
    end
  end

  always @(negedge clk) begin
    if (edge_idx > 0) begin
      checkOutput("model valid_o", longint'(bus.valid_o), longint'(m_valid));
      checkOutput("model data_o", longint'($signed(bus.data_o)), m_data);
      checkOutput("model sat_o", longint'(bus.sat_o), longint'(m_sat));
      checkOutput("model sat_sticky_o", longint'(bus.sat_sticky_o), longint'(m_sticky));
      checkOutput("model sat_count_o", longint'(bus.sat_count_o), m_count);
    end
  end

  task automatic applyStimulus(input longint data, input int shift);
    bus.data_i  = data[IN_WIDTH-1:0];
    bus.shift_i = shift[SHIFT_WIDTH-1:0];
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic waitValid(input string name, output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      lat++;
      if (bus.valid_o) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL %s: got no valid_o within 10 cycles, expected a pulse", name);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int     lat;
    int     vcount;
    longint got[$];
    int     shifts[7] = '{20, 19, 18, 21, 0, 63, 5};
    longint exp_out[7] = '{1, 2, 4, 1, 8191, 0, 8191};

    rst_ni        = 1'b0;
    bus.data_i    = '0;
    bus.valid_i   = 1'b0;
    bus.shift_i   = '0;
    bus.enable_i  = 1'b1;
    bus.clr_sat_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset data_o", longint'($signed(bus.data_o)), 0);
    checkOutput("reset valid_o", longint'(bus.valid_o), 0);
    checkOutput("reset sat_count_o", longint'(bus.sat_count_o), 0);
    rst_ni = 1'b1;
    @(negedge clk);

    $display("[TB] basic shift and latency");
    applyStimulus(6291456, 21);
    waitValid("t1 valid", lat);
    checkOutput("t1 latency", lat, 2);
    checkOutput("t1 data_o", longint'($signed(bus.data_o)), 3);
    checkOutput("t1 sat_o", longint'(bus.sat_o), 0);

    $display("[TB] round half up");
    applyStimulus(5 * 1048576, 21);
    waitValid("t2a valid", lat);
    checkOutput("t2 +2.5", longint'($signed(bus.data_o)), 3);
    applyStimulus(-5 * 1048576, 21);
    waitValid("t2b valid", lat);
    checkOutput("t2 -2.5", longint'($signed(bus.data_o)), -2);

    $display("[TB] saturation");
    applyStimulus(10000, 0);
    waitValid("t3a valid", lat);
    checkOutput("t3 +clip data_o", longint'($signed(bus.data_o)), 8191);
    checkOutput("t3 +clip sat_o", longint'(bus.sat_o), 1);
    applyStimulus(-10000, 0);
    waitValid("t3b valid", lat);
    checkOutput("t3 -clip data_o", longint'($signed(bus.data_o)), -8192);
    checkOutput("t3 -clip sat_o", longint'(bus.sat_o), 1);
    checkOutput("t3 sat_count_o", longint'(bus.sat_count_o), 2);
    checkOutput("t3 sat_sticky_o", longint'(bus.sat_sticky_o), 1);

    $display("[TB] shift clamp");
    applyStimulus(-(64'sd1 <<< 34), 63);
    waitValid("t4a valid", lat);
    checkOutput("t4 -2^34", longint'($signed(bus.data_o)), -1);
    applyStimulus((64'sd1 <<< 34) - 1, 63);
    waitValid("t4b valid", lat);
    checkOutput("t4 2^34-1", longint'($signed(bus.data_o)), 1);

    $display("[TB] clear priority and counter ceiling");
    bus.clr_sat_i = 1'b1;
    applyStimulus(10000, 0);
    waitValid("t5 valid", lat);
    checkOutput("t5 clr sat_o", longint'(bus.sat_o), 1);
    checkOutput("t5 clr count", longint'(bus.sat_count_o), 0);
    checkOutput("t5 clr sticky", longint'(bus.sat_sticky_o), 0);
    bus.clr_sat_i = 1'b0;
    bus.data_i    = 35'sd10000;
    bus.shift_i   = '0;
    for (int i = 0; i < 70000; i++) begin
      bus.valid_i = 1'b1;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t5 count ceiling", longint'(bus.sat_count_o), 65535);
    bus.enable_i = 1'b0;
    applyStimulus(-10000, 0);
    waitValid("t5 disabled valid", lat);
    checkOutput("t5 disabled data_o", longint'($signed(bus.data_o)), 0);
    checkOutput("t5 disabled sat_o", longint'(bus.sat_o), 0);
    checkOutput("t5 disabled count", longint'(bus.sat_count_o), 65535);
    bus.enable_i = 1'b1;
    @(negedge clk);

    $display("[TB] per-sample shift in a stream");
    bus.data_i = 35'sd1048576;
    for (int i = 0; i < 10; i++) begin
      if (i < 7) begin
        bus.shift_i = shifts[i][SHIFT_WIDTH-1:0];
        bus.valid_i = 1'b1;
      end else begin
        bus.valid_i = 1'b0;
      end
      @(negedge clk);
      if (bus.valid_o) got.push_back(longint'($signed(bus.data_o)));
    end
    checkOutput("t6 output count", longint'(got.size()), 7);
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      checkOutput($sformatf("t6 out[%0d]", i), got[i], exp_out[i]);
    end

    $display("[TB] reset mid-stream");
    bus.data_i  = 35'sd10000;
    bus.shift_i = '0;
    bus.valid_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.valid_i = 1'b0;
    rst_ni      = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.valid_o) vcount++;
      @(negedge clk);
    end
    checkOutput("t6 flushed valid_o", vcount, 0);
    checkOutput("t6 reset data_o", longint'($signed(bus.data_o)), 0);
    checkOutput("t6 reset count", longint'(bus.sat_count_o), 0);
    checkOutput("t6 reset sticky", longint'(bus.sat_sticky_o), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
